alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
- Consumes the hour/minute/second counts of the time-keeping counter chain and the 1 Hz enable tick; compares the current time against the programmed alarm time.
- Runs the ring / snooze / stop state machine and drives a square-wave buzzer output.
- Sits directly downstream of the MOD-N time counters and upstream of the buzzer pin and the status LEDs.

Parameters:
- RING_SEC, 60, seconds of ringing before auto-stop (1..65535)
- SNOOZE_SEC, 300, snooze duration in seconds (1..65535)
- MAX_SNOOZE, 3, maximum snoozes per alarm event (used only with the optional feature; 1..15)
- TONE_DIV, 25000, clk cycles per buzzer half-period (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick_1hz  in  1  one-clk-wide pulse, once per second
- cur_hour  in  5  current hour, 0..23
- cur_min  in  6  current minute, 0..59
- cur_sec  in  6  current second, 0..59
- alarm_hour  in  5  programmed alarm hour
- alarm_min  in  6  programmed alarm minute
- alarm_en  in  1  level; alarm armed when 1
- snooze_btn  in  1  debounced one-cycle pulse
- stop_btn  in  1  debounced one-cycle pulse
- state  out  2  0=IDLE, 1=ARMED, 2=RINGING, 3=SNOOZE
- ringing  out  1  high in RINGING
- buzzer  out  1  tone square wave while ringing
- snooze_remain  out  16  seconds left in SNOOZE, else 0

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, ringing=0, buzzer=0, snooze_remain=0; internal ring counter, tone counter and snooze-used counter are all 0.
- Registered outputs; every transition takes effect on the clk edge where its condition is sampled (latency 1 cycle).
- Match condition: tick_1hz=1 and cur_hour==alarm_hour and cur_min==alarm_min and cur_sec==0. It is evaluated only on tick cycles, so the alarm triggers once per day.
- Priority, highest first: rst > alarm_en==0 (any state -> IDLE, all counters cleared) > stop_btn > snooze_btn > tick-driven events.
- IDLE: alarm_en=1 -> ARMED.
- ARMED: match -> RINGING, ring counter cleared.
- RINGING:
  - stop_btn -> ARMED, snooze-used cleared.
  - snooze_btn -> SNOOZE, snooze_remain=SNOOZE_SEC, snooze-used +1.
  - Each tick increments the ring counter. On the tick where the ring counter reaches RING_SEC-1 -> ARMED, snooze-used cleared.
  - snooze_btn on that same tick wins.
- SNOOZE:
  - Each tick decrements snooze_remain.
  - On the tick with snooze_remain==1 -> RINGING, snooze_remain=0, ring counter cleared.
  - stop_btn -> ARMED, snooze_remain=0, snooze-used cleared.
  - snooze_btn ignored.
- Re-trigger: a match while in RINGING or SNOOZE is ignored.
- stop_btn and snooze_btn in IDLE or ARMED: ignored.
- Buzzer:
  - In RINGING, the tone counter counts clk 0..TONE_DIV-1. buzzer toggles when the counter wraps.
  - On entering RINGING: buzzer=0 and counter=0.
  - Outside RINGING: buzzer=0 and counter=0.
- Arithmetic: ring counter and snooze_remain are 16-bit unsigned. snooze_remain never underflows because the transition fires at value 1.

Optional Feature:
- Macro: ALARM_SNOOZE_LIMIT_EN.
- Defined: snooze-used is a 4-bit counter. snooze_btn in RINGING with snooze-used==MAX_SNOOZE is ignored and ringing continues; stop_btn or timeout still apply.
- Undefined: snoozes are unlimited, MAX_SNOOZE is unused, and no snooze-used counter is synthesised.

Test Plan:
- Test parameters for all scenarios: RING_SEC=5, SNOOZE_SEC=3, TONE_DIV=2.
- Trigger: alarm 07:30, alarm_en=1, time driven to 07:29:59 then a tick with 07:30:00 -> state=RINGING and ringing=1 the next cycle; buzzer toggles every 2 clk cycles.
- Timeout: no buttons after the trigger -> state returns to ARMED on the 5th tick; buzzer=0; a tick at 07:30:01 does not retrigger.
- Snooze: snooze_btn in RINGING -> SNOOZE with snooze_remain=3; ticks give 2, 1, then RINGING with snooze_remain=0; a stop_btn then gives ARMED.
- Priority: stop_btn and snooze_btn in the same cycle during RINGING -> ARMED. alarm_en dropped during SNOOZE -> IDLE with snooze_remain=0.
- Reset mid-ring: rst high for 1 cycle while RINGING with buzzer=1 -> state=IDLE, buzzer=0, ringing=0 on the next edge.
- Limit (ALARM_SNOOZE_LIMIT_EN defined, MAX_SNOOZE=2): third snooze_btn -> stays RINGING. Undefined build: third snooze_btn -> SNOOZE.

Source files
------------

// File: rtl/alarm_controller_if.sv
// alarm_controller_if: time/alarm inputs, user buttons and status outputs of the alarm controller.
// master = the side that supplies time and buttons, slave = the alarm controller itself.
interface alarm_controller_if;
    logic        tick_1hz;
    logic [4:0]  cur_hour;
    logic [5:0]  cur_min;
    logic [5:0]  cur_sec;
    logic [4:0]  alarm_hour;
    logic [5:0]  alarm_min;
    logic        alarm_en;
    logic        snooze_btn;
    logic        stop_btn;
    logic [1:0]  state;
    logic        ringing;
    logic        buzzer;
    logic [15:0] snooze_remain;

    modport master (
        output tick_1hz, cur_hour, cur_min, cur_sec,
        output alarm_hour, alarm_min, alarm_en, snooze_btn, stop_btn,
        input  state, ringing, buzzer, snooze_remain
    );

    modport slave (
        input  tick_1hz, cur_hour, cur_min, cur_sec,
        input  alarm_hour, alarm_min, alarm_en, snooze_btn, stop_btn,
        output state, ringing, buzzer, snooze_remain
    );
endinterface

// File: rtl/alarm_controller.sv
// alarm_controller: compares the running time against the alarm time, runs the
// IDLE/ARMED/RINGING/SNOOZE state machine and drives a square-wave buzzer.
// Optional macro ALARM_SNOOZE_LIMIT_EN caps snoozes per alarm event at MAX_SNOOZE.
module alarm_controller #(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3,
    parameter int unsigned TONE_DIV   = 25000
) (
    input  logic              clk,
    input  logic              rst,
    alarm_controller_if.slave bus
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    // Elaboration-time range guard for the snooze limit
    if (MAX_SNOOZE < 1 || MAX_SNOOZE > 15) begin : g_bad_max_snooze
        $error("alarm_controller: MAX_SNOOZE must be 1..15");
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    ring_q, ring_d;
    logic [CNT_W-1:0]    remain_q, remain_d;
    logic [TONE_W-1:0]   tone_q, tone_d;
    logic                buzzer_q, buzzer_d;
    logic                ringing_q;
    logic                match_c;
    logic                snooze_ok_c;

`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam int unsigned USED_W = 4;
    logic [USED_W-1:0]   used_q, used_d;

    // Snooze is refused once the per-event budget is spent
    always_comb begin
        snooze_ok_c = (used_q != USED_W'(MAX_SNOOZE));
    end
`else
    // Unlimited snoozes
    always_comb begin
        snooze_ok_c = 1'b1;
    end
`endif

    // Alarm match is only meaningful on the 1 Hz tick at second zero
    always_comb begin
        match_c = bus.tick_1hz
               && (bus.cur_hour == bus.alarm_hour)
               && (bus.cur_min  == bus.alarm_min)
               && (bus.cur_sec  == 6'd0);
    end

    // Next-state, counters and tone generation
    always_comb begin
        state_d  = state_q;
        ring_d   = ring_q;
        remain_d = remain_q;
        tone_d   = '0;
        buzzer_d = 1'b0;
`ifdef ALARM_SNOOZE_LIMIT_EN
        used_d   = used_q;
`endif

        if (!bus.alarm_en) begin
            state_d  = IDLE;
            ring_d   = '0;
            remain_d = '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
            used_d   = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    if (match_c) begin
                        state_d = RINGING;
                        ring_d  = '0;
                    end
                end
                RINGING: begin
                    if (bus.stop_btn) begin
                        state_d = ARMED;
`ifdef ALARM_SNOOZE_LIMIT_EN
                        used_d  = '0;
`endif
                    end else if (bus.snooze_btn && snooze_ok_c) begin
                        state_d  = SNOOZE;
                        remain_d = CNT_W'(SNOOZE_SEC);
`ifdef ALARM_SNOOZE_LIMIT_EN
                        used_d   = used_q + USED_W'(1);
`endif
                    end else if (bus.tick_1hz) begin
                        if (ring_q == CNT_W'(RING_SEC - 1)) begin
                            state_d = ARMED;
`ifdef ALARM_SNOOZE_LIMIT_EN
                            used_d  = '0;
`endif
                        end else begin
                            ring_d = ring_q + CNT_W'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (bus.stop_btn) begin
                        state_d  = ARMED;
                        remain_d = '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
                        used_d   = '0;
`endif
                    end else if (bus.tick_1hz) begin
                        if (remain_q == CNT_W'(1)) begin
                            state_d  = RINGING;
                            remain_d = '0;
                            ring_d   = '0;
                        end else begin
                            remain_d = remain_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Tone runs only while staying in RINGING; entry and exit restart it silent
        if (state_q == RINGING && state_d == RINGING) begin
            if (tone_q == TONE_W'(TONE_DIV - 1)) begin
                tone_d   = '0;
                buzzer_d = ~buzzer_q;
            end else begin
                tone_d   = tone_q + TONE_W'(1);
                buzzer_d = buzzer_q;
            end
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ring_q    <= '0;
            remain_q  <= '0;
            tone_q    <= '0;
            buzzer_q  <= 1'b0;
            ringing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ring_q    <= ring_d;
            remain_q  <= remain_d;
            tone_q    <= tone_d;
            buzzer_q  <= buzzer_d;
            ringing_q <= (state_d == RINGING);
        end
    end

`ifdef ALARM_SNOOZE_LIMIT_EN
    // Snooze-used counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            used_q <= '0;
        end else begin
            used_q <= used_d;
        end
    end
`endif

    assign bus.state         = state_q;
    assign bus.ringing       = ringing_q;
    assign bus.buzzer        = buzzer_q;
    assign bus.snooze_remain = remain_q;

endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed sequence with a scoreboard of expected outputs per cycle.
module tb_alarm_controller;

    localparam int unsigned RING_SEC   = 5;
    localparam int unsigned SNOOZE_SEC = 3;
    localparam int unsigned MAX_SNOOZE = 2;
    localparam int unsigned TONE_DIV   = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RING = 2'd2;
    localparam logic [1:0] S_SNZ  = 2'd3;

    typedef struct packed {
        logic [1:0]  st;
        logic        rg;
        logic        bz;
        logic [15:0] rem;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    exp_t  sb_q[$];
    string tag_q[$];

    alarm_controller_if bus ();

    alarm_controller #(
        .RING_SEC  (RING_SEC),
        .SNOOZE_SEC(SNOOZE_SEC),
        .MAX_SNOOZE(MAX_SNOOZE),
        .TONE_DIV  (TONE_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        bus.cur_hour = h;
        bus.cur_min  = m;
        bus.cur_sec  = s;
    endtask

    // One clock: drive pulses, push expectation, pop and compare after the edge
    task automatic cyc(input string tag, input bit t, input bit sz, input bit sp,
                       input logic [1:0] st, input logic rg, input logic bz,
                       input logic [15:0] rem);
        exp_t e;
        string tg;
        bus.tick_1hz   = t;
        bus.snooze_btn = sz;
        bus.stop_btn   = sp;
        sb_q.push_back('{st: st, rg: rg, bz: bz, rem: rem});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        bus.tick_1hz   = 1'b0;
        bus.snooze_btn = 1'b0;
        bus.stop_btn   = 1'b0;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty: observed 0 entries required 1", tag);
            return;
        end
        e  = sb_q.pop_front();
        tg = tag_q.pop_front();
        assert (bus.state === e.st) else begin
            errors++;
            $error("FAIL %s state: observed %0d required %0d", tg, bus.state, e.st);
        end
        checks++;
        assert (bus.ringing === e.rg) else begin
            errors++;
            $error("FAIL %s ringing: observed %b required %b", tg, bus.ringing, e.rg);
        end
        checks++;
        assert (bus.buzzer === e.bz) else begin
            errors++;
            $error("FAIL %s buzzer: observed %b required %b", tg, bus.buzzer, e.bz);
        end
        checks++;
        assert (bus.snooze_remain === e.rem) else begin
            errors++;
            $error("FAIL %s snooze_remain: observed %0d required %0d", tg, bus.snooze_remain, e.rem);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.tick_1hz   = 1'b0;
        bus.snooze_btn = 1'b0;
        bus.stop_btn   = 1'b0;
        bus.alarm_en   = 1'b0;
        bus.alarm_hour = 5'd7;
        bus.alarm_min  = 6'd30;
        set_time(5'd7, 6'd29, 6'd59);

        // Reset and arming
        cyc("reset", 0, 0, 0, S_IDLE, 0, 0, 16'd0);
        rst = 1'b0;
        cyc("idle_disabled", 0, 0, 0, S_IDLE, 0, 0, 16'd0);
        bus.alarm_en = 1'b1;
        cyc("arm", 0, 0, 0, S_ARM, 0, 0, 16'd0);
        cyc("tick_072959", 1, 0, 0, S_ARM, 0, 0, 16'd0);
        set_time(5'd7, 6'd30, 6'd0);
        cyc("match_no_tick", 0, 0, 0, S_ARM, 0, 0, 16'd0);

        // Trigger and tone: buzzer flips every TONE_DIV cycles
        cyc("trigger", 1, 0, 0, S_RING, 1, 0, 16'd0);
        cyc("tone_k1", 0, 0, 0, S_RING, 1, 0, 16'd0);
        cyc("tone_k2", 0, 0, 0, S_RING, 1, 1, 16'd0);
        cyc("tone_k3", 0, 0, 0, S_RING, 1, 1, 16'd0);
        cyc("tone_k4", 0, 0, 0, S_RING, 1, 0, 16'd0);

        // Timeout on the fifth tick after the trigger
        set_time(5'd7, 6'd30, 6'd1);
        cyc("ring_tick1", 1, 0, 0, S_RING, 1, 0, 16'd0);
        cyc("ring_tick2", 1, 0, 0, S_RING, 1, 1, 16'd0);
        cyc("ring_tick3", 1, 0, 0, S_RING, 1, 1, 16'd0);
        cyc("ring_tick4", 1, 0, 0, S_RING, 1, 0, 16'd0);
        cyc("timeout", 1, 0, 0, S_ARM, 0, 0, 16'd0);
        cyc("no_retrigger_0730_01", 1, 0, 0, S_ARM, 0, 0, 16'd0);

        // Snooze countdown and return to ringing
        set_time(5'd7, 6'd30, 6'd0);
        cyc("trigger2", 1, 0, 0, S_RING, 1, 0, 16'd0);
        cyc("snooze", 0, 1, 0, S_SNZ, 0, 0, 16'd3);
        cyc("snooze_btn_ignored", 0, 1, 0, S_SNZ, 0, 0, 16'd3);
        cyc("snz_tick_2", 1, 0, 0, S_SNZ, 0, 0, 16'd2);
        cyc("snz_tick_1_match_ignored", 1, 0, 0, S_SNZ, 0, 0, 16'd1);
        cyc("snz_hold", 0, 0, 0, S_SNZ, 0, 0, 16'd1);
        cyc("snz_expire", 1, 0, 0, S_RING, 1, 0, 16'd0);
        cyc("reret_k1", 0, 0, 0, S_RING, 1, 0, 16'd0);
        cyc("reret_k2", 0, 0, 0, S_RING, 1, 1, 16'd0);
        cyc("stop", 0, 0, 1, S_ARM, 0, 0, 16'd0);

        // Buttons ignored while armed
        cyc("armed_snooze_ign", 0, 1, 0, S_ARM, 0, 0, 16'd0);
        cyc("armed_stop_ign", 0, 0, 1, S_ARM, 0, 0, 16'd0);

        // Priority: stop over snooze, disable over everything
        cyc("trigger3", 1, 0, 0, S_RING, 1, 0, 16'd0);
        cyc("stop_and_snooze", 0, 1, 1, S_ARM, 0, 0, 16'd0);
        cyc("trigger4", 1, 0, 0, S_RING, 1, 0, 16'd0);
        cyc("snooze4", 0, 1, 0, S_SNZ, 0, 0, 16'd3);
        cyc("snz4_tick", 1, 0, 0, S_SNZ, 0, 0, 16'd2);
        bus.alarm_en = 1'b0;
        cyc("disable_in_snooze", 1, 0, 0, S_IDLE, 0, 0, 16'd0);
        bus.alarm_en = 1'b1;
        cyc("rearm", 0, 0, 0, S_ARM, 0, 0, 16'd0);

        // Snooze on the timeout tick takes precedence
        cyc("trigger5", 1, 0, 0, S_RING, 1, 0, 16'd0);
        set_time(5'd7, 6'd30, 6'd1);
        cyc("t5_tick1", 1, 0, 0, S_RING, 1, 0, 16'd0);
        cyc("t5_tick2", 1, 0, 0, S_RING, 1, 1, 16'd0);
        cyc("t5_tick3", 1, 0, 0, S_RING, 1, 1, 16'd0);
        cyc("t5_tick4", 1, 0, 0, S_RING, 1, 0, 16'd0);
        cyc("snooze_on_timeout", 1, 1, 0, S_SNZ, 0, 0, 16'd3);
        cyc("stop_in_snooze", 0, 0, 1, S_ARM, 0, 0, 16'd0);

        // Reset while the buzzer is high
        set_time(5'd7, 6'd30, 6'd0);
        cyc("trigger6", 1, 0, 0, S_RING, 1, 0, 16'd0);
        cyc("t6_k1", 0, 0, 0, S_RING, 1, 0, 16'd0);
        cyc("t6_k2_buzz", 0, 0, 0, S_RING, 1, 1, 16'd0);
        rst = 1'b1;
        cyc("reset_mid_ring", 0, 0, 0, S_IDLE, 0, 0, 16'd0);
        rst = 1'b0;
        cyc("after_reset", 0, 0, 0, S_ARM, 0, 0, 16'd0);

        // Snooze budget: third snooze in one event
        cyc("trigger7", 1, 0, 0, S_RING, 1, 0, 16'd0);
        set_time(5'd7, 6'd31, 6'd0);
        cyc("lim_snz1", 0, 1, 0, S_SNZ, 0, 0, 16'd3);
        cyc("lim_a2", 1, 0, 0, S_SNZ, 0, 0, 16'd2);
        cyc("lim_a1", 1, 0, 0, S_SNZ, 0, 0, 16'd1);
        cyc("lim_a0", 1, 0, 0, S_RING, 1, 0, 16'd0);
        cyc("lim_snz2", 0, 1, 0, S_SNZ, 0, 0, 16'd3);
        cyc("lim_b2", 1, 0, 0, S_SNZ, 0, 0, 16'd2);
        cyc("lim_b1", 1, 0, 0, S_SNZ, 0, 0, 16'd1);
        cyc("lim_b0", 1, 0, 0, S_RING, 1, 0, 16'd0);
`ifdef ALARM_SNOOZE_LIMIT_EN
        cyc("lim_snz3_refused", 0, 1, 0, S_RING, 1, 0, 16'd0);
        cyc("lim_k2", 0, 0, 0, S_RING, 1, 1, 16'd0);
`else
        cyc("lim_snz3_allowed", 0, 1, 0, S_SNZ, 0, 0, 16'd3);
        cyc("lim_snz3_hold", 0, 0, 0, S_SNZ, 0, 0, 16'd3);
`endif
        cyc("lim_stop", 0, 0, 1, S_ARM, 0, 0, 16'd0);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d entries required 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
